instr_fetch: RTL and testbench

//  IF stage of the LEGv8 datapath. Owns the PC, runs a req/ready handshake to

---
 rtl/instr_fetch.sv | 160 ++++++++++++++++
 tb/tb_instr_fetch.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: IF stage of the LEGv8 datapath.
// Owns the PC and runs a req/ready handshake to instruction memory. The fetched
// word is held in the IF/ID register. Taken branches reported by main_control
// redirect the PC to a target computed here from the IF/ID word.
// A one-entry skid buffer catches a word that returns while ID is stalled. A
// redirect that arrives mid-request drains the pending fetch before retargeting.
module instr_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        BrTaken,
    input  logic        UncondBr,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [63:0] instr_pc,
    output logic        instr_valid,
    output logic [10:0] opcode
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,   // request outstanding at pc
        DRAIN = 2'd1,   // request outstanding at a stale pc; redirect parked in tgt
        HELD  = 2'd2    // slot stalled, next word parked in skid, no request
    } fetchState_t;

    typedef struct packed {
        logic [31:0] word;
        logic [63:0] pc;
    } skid_t;

    fetchState_t state, stateNext;
    logic [63:0] pc, pcNext;
    logic [63:0] tgt, tgtNext;
    logic [31:0] instrQ, instrNext;
    logic [63:0] instrPcQ, instrPcNext;
    logic        instrValidQ, instrValidNext;
    skid_t       skid, skidNext;

    logic        consume;
    logic        redirect;
    logic [63:0] immSext;
    logic [63:0] target;
    logic [63:0] pcPlus4;

    // Branch target from the word in IF/ID: B uses imm26, CB* uses imm19.
    always_comb begin
        immSext = '0;
        if (UncondBr) begin
            immSext = {{38{instrQ[25]}}, instrQ[25:0]};
        end else begin
            immSext = {{45{instrQ[23]}}, instrQ[23:5]};
        end
        target  = instrPcQ + (immSext << 2);
        pcPlus4 = pc + 64'd4;
    end

    assign consume  = instrValidQ & ~stall;
    assign redirect = consume & BrTaken;

    // Request is gated by reset_n so it drops as soon as reset asserts.
    assign imem_req    = reset_n & (state != HELD);
    assign imem_addr   = pc;
    assign instr       = instrQ;
    assign instr_pc    = instrPcQ;
    assign instr_valid = instrValidQ;
    assign opcode      = instrQ[31:21];

    // Next-state and next IF/ID contents for each fetch state.
    always_comb begin
        stateNext      = state;
        pcNext         = pc;
        tgtNext        = tgt;
        instrNext      = instrQ;
        instrPcNext    = instrPcQ;
        instrValidNext = instrValidQ;
        skidNext       = skid;

        unique case (state)
            FETCH: begin
                if (imem_ready) begin
                    if (redirect) begin
                        // Word fetched past a taken branch is dropped.
                        pcNext         = target;
                        instrValidNext = 1'b0;
                    end else if (!instrValidQ || !stall) begin
                        instrNext      = imem_rdata;
                        instrPcNext    = pc;
                        instrValidNext = 1'b1;
                        pcNext         = pcPlus4;
                    end else begin
                        // Slot occupied and stalled: park the word and stop fetching.
                        skidNext.word = imem_rdata;
                        skidNext.pc   = pc;
                        pcNext        = pcPlus4;
                        stateNext     = HELD;
                    end
                end else if (redirect) begin
                    // Address must stay put until the pending request completes.
                    tgtNext        = target;
                    instrValidNext = 1'b0;
                    stateNext      = DRAIN;
                end else if (consume) begin
                    instrValidNext = 1'b0;
                end
            end

            DRAIN: begin
                if (imem_ready) begin
                    pcNext    = tgt;
                    stateNext = FETCH;
                end
            end

            HELD: begin
                if (!stall) begin
                    if (BrTaken) begin
                        pcNext         = target;
                        instrValidNext = 1'b0;
                    end else begin
                        instrNext      = skid.word;
                        instrPcNext    = skid.pc;
                        instrValidNext = 1'b1;
                    end
                    stateNext = FETCH;
                end
            end

            default: begin
                stateNext = FETCH;
            end
        endcase
    end

    // State, PC and IF/ID registers; reset abandons any outstanding request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            tgt         <= '0;
            instrQ      <= '0;
            instrPcQ    <= '0;
            instrValidQ <= 1'b0;
            skid        <= '0;
        end else begin
            state       <= stateNext;
            pc          <= pcNext;
            tgt         <= tgtNext;
            instrQ      <= instrNext;
            instrPcQ    <= instrPcNext;
            instrValidQ <= instrValidNext;
            skid        <= skidNext;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed scenarios plus a randomized run checked against a
// program-order model (each consumed instruction must be the next one in the
// architectural stream; taken branches jump to the computed target).
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall, BrTaken, UncondBr, imem_ready;
    logic        imem_req, instr_valid;
    logic [63:0] imem_addr, instr_pc;
    logic [31:0] imem_rdata, instr;
    logic [10:0] opcode;

    logic        imem_req2, instr_valid2;
    logic [63:0] imem_addr2, instr_pc2;
    logic [31:0] imem_rdata2, instr2;
    logic [10:0] opcode2;

    int nChecks = 0;
    int nErrors = 0;
    int progGen = 0;

    logic [31:0] prog [logic [63:0]];

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(64'h0)) dut (
        .clk(clk), .reset_n(reset_n), .stall(stall), .BrTaken(BrTaken),
        .UncondBr(UncondBr), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr(instr),
        .instr_pc(instr_pc), .instr_valid(instr_valid), .opcode(opcode)
    );

    instr_fetch #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut2 (
        .clk(clk), .reset_n(reset_n), .stall(stall), .BrTaken(BrTaken),
        .UncondBr(UncondBr), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata2), .instr(instr2),
        .instr_pc(instr_pc2), .instr_valid(instr_valid2), .opcode(opcode2)
    );

    // Memory image: explicit program words, otherwise a hash of the address.
    function automatic logic [31:0] memWord(input logic [63:0] a);
        if (prog.exists(a)) return prog[a];
        return (a[33:2] * 32'h9E37_79B1) ^ 32'hC001_D00D ^ a[63:32];
    endfunction

    always @(imem_addr or imem_addr2 or progGen) begin
        imem_rdata  = memWord(imem_addr);
        imem_rdata2 = memWord(imem_addr2);
    end

    // Architectural branch target: pc + 4*signed(imm), wrapping mod 2^64.
    function automatic logic [63:0] branchTarget(input logic [63:0] p, input logic [31:0] w,
                                                 input logic u);
        longint imm;
        if (u) begin
            imm = longint'(w[25:0]);
            if (imm >= 64'sd33554432) imm = imm - 64'sd67108864;
        end else begin
            imm = longint'(w[23:5]);
            if (imm >= 64'sd262144) imm = imm - 64'sd524288;
        end
        return p + 64'(imm * 4);
    endfunction

    task automatic doReset();
        reset_n = 1'b0; stall = 1'b0; BrTaken = 1'b0; UncondBr = 1'b0; imem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
    endtask

    // Advance until instr holds a live word at pc p (bounded).
    task automatic waitPc(input logic [63:0] p, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (instr_valid === 1'b1 && instr_pc === p) ok = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic test_reset();
        prog.delete(); progGen++;
        reset_n = 1'b0; stall = 1'b0; BrTaken = 1'b0; UncondBr = 1'b0; imem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        nChecks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0 ||
            instr_pc !== 64'h0 || opcode !== 11'h0) begin
            nErrors++;
            $display("FAIL reset_state: req=%b valid=%b instr=%h pc=%h op=%h, want all 0",
                     imem_req, instr_valid, instr, instr_pc, opcode);
        end
        reset_n = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            nChecks++;
            if (imem_req !== 1'b1 || imem_addr !== 64'(4 * i)) begin
                nErrors++;
                $display("FAIL seq_addr[%0d]: req=%b addr=%h, want req=1 addr=%h",
                         i, imem_req, imem_addr, 64'(4 * i));
            end
            nChecks++;
            if (i == 0) begin
                if (instr_valid !== 1'b0) begin
                    nErrors++;
                    $display("FAIL seq_valid0: valid=%b, want 0", instr_valid);
                end
            end else if (instr_valid !== 1'b1 || instr_pc !== 64'(4 * (i - 1)) ||
                         instr !== memWord(64'(4 * (i - 1)))) begin
                nErrors++;
                $display("FAIL seq_instr[%0d]: valid=%b pc=%h instr=%h, want 1 %h %h", i,
                         instr_valid, instr_pc, instr, 64'(4 * (i - 1)), memWord(64'(4 * (i - 1))));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_branch_b();
        bit ok;
        logic [25:0] imm;
        logic [63:0] exp;
        logic [31:0] w;
        for (int k = 0; k < 2; k++) begin
            imm = (k == 0) ? 26'd3 : 26'h3FF_FFFF;
            exp = (k == 0) ? 64'h1C : 64'h0C;
            w = {6'b000101, imm};
            prog.delete(); prog[64'h10] = w; progGen++;
            doReset();
            waitPc(64'h10, ok);
            nChecks++;
            if (!ok) begin
                nErrors++;
                $display("FAIL b_reach[%0d]: pc 0x10 never valid", k);
            end else begin
                nChecks++;
                if (imem_addr !== 64'h14 || opcode !== w[31:21]) begin
                    nErrors++;
                    $display("FAIL b_pre[%0d]: addr=%h op=%h, want 14 %h", k, imem_addr, opcode, w[31:21]);
                end
                BrTaken = 1'b1; UncondBr = 1'b1;
                @(negedge clk);
                BrTaken = 1'b0; UncondBr = 1'b0;
                nChecks++;
                if (imem_req !== 1'b1 || imem_addr !== exp || instr_valid !== 1'b0) begin
                    nErrors++;
                    $display("FAIL b_redirect[%0d]: req=%b addr=%h valid=%b, want 1 %h 0",
                             k, imem_req, imem_addr, instr_valid, exp);
                end
                @(negedge clk);
                nChecks++;
                if (instr_valid !== 1'b1 || instr_pc !== exp || instr !== memWord(exp)) begin
                    nErrors++;
                    $display("FAIL b_target[%0d]: valid=%b pc=%h instr=%h, want 1 %h %h",
                             k, instr_valid, instr_pc, instr, exp, memWord(exp));
                end
            end
        end
    endtask

    task automatic test_cbz_drain();
        bit ok;
        prog.delete(); prog[64'h40] = {8'hB4, 19'h7FFFE, 5'd3}; progGen++;
        doReset();
        waitPc(64'h40, ok);
        nChecks++;
        if (!ok) begin
            nErrors++;
            $display("FAIL cbz_reach: pc 0x40 never valid");
        end else begin
            imem_ready = 1'b0; BrTaken = 1'b1; UncondBr = 1'b0;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                BrTaken = 1'b0;
                nChecks++;
                if (imem_req !== 1'b1 || imem_addr !== 64'h44 || instr_valid !== 1'b0) begin
                    nErrors++;
                    $display("FAIL cbz_drain[%0d]: req=%b addr=%h valid=%b, want 1 44 0",
                             k, imem_req, imem_addr, instr_valid);
                end
                if (k == 2) imem_ready = 1'b1;
            end
            @(negedge clk);
            nChecks++;
            if (imem_req !== 1'b1 || imem_addr !== 64'h38 || instr_valid !== 1'b0) begin
                nErrors++;
                $display("FAIL cbz_target: req=%b addr=%h valid=%b, want 1 38 0",
                         imem_req, imem_addr, instr_valid);
            end
            @(negedge clk);
            nChecks++;
            if (instr_valid !== 1'b1 || instr_pc !== 64'h38 || instr !== memWord(64'h38)) begin
                nErrors++;
                $display("FAIL cbz_word: valid=%b pc=%h instr=%h, want 1 38 %h",
                         instr_valid, instr_pc, instr, memWord(64'h38));
            end
        end
    endtask

    task automatic test_stall_skid();
        bit ok;
        prog.delete(); progGen++;
        doReset();
        waitPc(64'h8, ok);
        nChecks++;
        if (!ok || imem_addr !== 64'hC) begin
            nErrors++;
            $display("FAIL stall_reach: ok=%b addr=%h, want 1 c", ok, imem_addr);
        end else begin
            stall = 1'b1;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                nChecks++;
                if (imem_req !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 64'h8) begin
                    nErrors++;
                    $display("FAIL stall_held[%0d]: req=%b valid=%b pc=%h, want 0 1 8",
                             k, imem_req, instr_valid, instr_pc);
                end
                if (k == 3) stall = 1'b0;
            end
            @(negedge clk);
            nChecks++;
            if (instr_valid !== 1'b1 || instr_pc !== 64'hC || instr !== memWord(64'hC) ||
                imem_req !== 1'b1 || imem_addr !== 64'h10) begin
                nErrors++;
                $display("FAIL stall_skid: valid=%b pc=%h instr=%h req=%b addr=%h, want 1 c %h 1 10",
                         instr_valid, instr_pc, instr, imem_req, imem_addr, memWord(64'hC));
            end
            @(negedge clk);
            nChecks++;
            if (instr_valid !== 1'b1 || instr_pc !== 64'h10 || instr !== memWord(64'h10)) begin
                nErrors++;
                $display("FAIL stall_next: valid=%b pc=%h, want 1 10", instr_valid, instr_pc);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        prog.delete(); progGen++;
        doReset();
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (imem_addr === 64'h20) ok = 1'b1;
            else @(negedge clk);
        end
        nChecks++;
        if (!ok) begin
            nErrors++;
            $display("FAIL rmid_reach: addr 0x20 never issued");
        end else begin
            imem_ready = 1'b0;
            @(negedge clk);
            nChecks++;
            if (imem_req !== 1'b1 || imem_addr !== 64'h20) begin
                nErrors++;
                $display("FAIL rmid_pend: req=%b addr=%h, want 1 20", imem_req, imem_addr);
            end
            #2 reset_n = 1'b0;
            #1;
            nChecks++;
            if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0 ||
                instr_pc !== 64'h0 || opcode !== 11'h0) begin
                nErrors++;
                $display("FAIL rmid_async: req=%b valid=%b instr=%h pc=%h, want all 0",
                         imem_req, instr_valid, instr, instr_pc);
            end
            @(negedge clk);
            reset_n = 1'b1; imem_ready = 1'b1;
            #1;
            nChecks++;
            if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
                nErrors++;
                $display("FAIL rmid_restart: req=%b addr=%h, want 1 0", imem_req, imem_addr);
            end
            @(negedge clk);
            nChecks++;
            if (instr_valid !== 1'b1 || instr_pc !== 64'h0 || instr !== memWord(64'h0)) begin
                nErrors++;
                $display("FAIL rmid_first: valid=%b pc=%h instr=%h, want 1 0 %h",
                         instr_valid, instr_pc, instr, memWord(64'h0));
            end
        end
    endtask

    task automatic test_wrap();
        prog.delete(); progGen++;
        doReset();
        nChecks++;
        if (imem_req2 !== 1'b1 || imem_addr2 !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            nErrors++;
            $display("FAIL wrap_first: req=%b addr=%h, want 1 fffffffffffffffc", imem_req2, imem_addr2);
        end
        @(negedge clk);
        nChecks++;
        if (imem_addr2 !== 64'h0 || instr_valid2 !== 1'b1 || instr_pc2 !== 64'hFFFF_FFFF_FFFF_FFFC ||
            instr2 !== memWord(64'hFFFF_FFFF_FFFF_FFFC)) begin
            nErrors++;
            $display("FAIL wrap_second: addr=%h valid=%b pc=%h, want 0 1 fffffffffffffffc",
                     imem_addr2, instr_valid2, instr_pc2);
        end
    endtask

    task automatic test_random();
        logic [63:0] expPc, prevAddr, exPcSeen;
        logic [31:0] w;
        bit prevPend;
        int consumes;
        prog.delete(); progGen++;
        doReset();
        expPc = 64'h0; prevPend = 1'b0; consumes = 0; prevAddr = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            imem_ready = ($urandom_range(0, 9) < 7);
            stall      = ($urandom_range(0, 9) < 3);
            BrTaken    = ($urandom_range(0, 9) < 2);
            UncondBr   = 1'($urandom_range(0, 1));
            if (prevPend) begin
                nChecks++;
                if (imem_addr !== prevAddr || imem_req !== 1'b1) begin
                    nErrors++;
                    $display("FAIL rnd_addr_hold @%0d: req=%b addr=%h, want 1 %h",
                             cyc, imem_req, imem_addr, prevAddr);
                end
            end
            prevPend = imem_req && !imem_ready;
            prevAddr = imem_addr;
            if (instr_valid === 1'b1 && !stall) begin
                w = memWord(expPc);
                exPcSeen = instr_pc;
                consumes++;
                nChecks++;
                if (exPcSeen !== expPc || instr !== w || opcode !== w[31:21]) begin
                    nErrors++;
                    $display("FAIL rnd_stream @%0d: pc=%h instr=%h op=%h, want %h %h %h",
                             cyc, exPcSeen, instr, opcode, expPc, w, w[31:21]);
                end
                expPc = BrTaken ? branchTarget(expPc, w, UncondBr) : expPc + 64'd4;
            end
            @(negedge clk);
        end
        BrTaken = 1'b0; stall = 1'b0;
        nChecks++;
        if (consumes < 200) begin
            nErrors++;
            $display("FAIL rnd_progress: consumed=%0d, want >= 200", consumes);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; stall = 1'b0; BrTaken = 1'b0; UncondBr = 1'b0; imem_ready = 1'b0;
        test_reset();
        test_branch_b();
        test_cbz_drain();
        test_stall_skid();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
